uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter with a configurable frame format: data width, parity mode and stop-bit count. A write FIFO decouples the producer (the matrix result path) from the serial line. Words written to the FIFO are serialised LSB-first. When the FIFO holds more words, frames go out back-to-back with no idle gap. This block is the next-generation serial output stage of the design.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- BAUD_TICK, CLK_FREQ/BAUD_RATE, clocks per bit (integer division); must be ≥ 2
- DATA_BITS, 8, data bits per frame (legal range 5–9)
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 16, FIFO entries (power of two, ≥ 2)

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  reset, asynchronous, active-high
- data  input  DATA_BITS  word to enqueue
- start  input  1  write strobe; enqueues `data` on the edge where it is sampled high and `full` = 0
- full  output  1  FIFO holds FIFO_DEPTH words
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued (excludes the frame in flight)
- overflow  output  1  one-cycle pulse when `start` is sampled high while `full` = 1
- tx  output  1  serial line; idles high
- busy  output  1  high while a frame is in flight or `fifo_count` ≠ 0

## Operation
- Reset (asynchronous):
  - `tx` = 1; `busy`, `full`, `overflow`, `fifo_count` = 0.
  - FIFO pointers are cleared and the FSM returns to IDLE.
  - A frame in progress is aborted; the line returns high immediately.
- FIFO:
  - Write is accepted when `start` = 1 and the registered `full` = 0.
  - If `start` = 1 while `full` = 1, the word is dropped and `overflow` pulses. This holds even if a pop occurs on the same edge.
  - A simultaneous accepted write and pop leaves `fifo_count` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE, `fifo_count` ≠ 0: pop the head word into the shift register, clear the baud and bit counters, go to START, drive `tx` = 0.
- Bit timing: every bit holds `tx` for exactly BAUD_TICK clocks. A baud counter runs 0..BAUD_TICK−1 and advances the state or bit on its terminal count.
- START → DATA: `tx` = bit 0.
- DATA: shifts out DATA_BITS bits, LSB first.
  - After the last data bit, go to PARITY if PARITY ≠ 0, else to STOP.
- PARITY: `tx` = XOR of the data bits for even parity, or its inverse for odd parity. The total count of ones over data plus parity is then even or odd respectively.
- STOP: `tx` = 1 for STOP_BITS × BAUD_TICK clocks. At its terminal count:
  - FIFO non-empty: pop and go straight to START (`tx` = 0 on that same edge).
  - FIFO empty: go to IDLE.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_TICK clocks.
- `busy` is registered. It equals (state ≠ IDLE) OR (`fifo_count` ≠ 0), evaluated on the next-state values.
- PARITY values 3 and other out-of-range parameters are illegal. Behaviour is unspecified; elaboration-time checks are recommended.

## Timing
- `start` sampled at edge T → `fifo_count` increments at T and `busy` = 1 from T.
- At edge T+1 the FSM pops from an idle state: `tx` falls at T+1 and `fifo_count` decrements.
- `full` and `fifo_count` update on the same edge as the write or pop that changes them.
- `overflow` is high for the single cycle following the rejected edge.
- Back-to-back frames have zero idle clocks between the last stop bit and the next start bit.
- `busy` falls on the edge that ends the last stop bit of the final queued frame.

## Test plan
Use CLK_FREQ = 1600 and BAUD_RATE = 100, so BAUD_TICK = 16.
1. 8N1, write 0xA5 → `tx` low 1 cycle after the write. Bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 clocks. `busy` high for 161 clocks (write edge through frame end), then `tx` = 1.
2. DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, write 0x41 → bits 0,1,0,0,0,0,0,1, then parity 0, then 1,1. Repeat with PARITY = 1 → parity bit 1.
3. FIFO_DEPTH = 16, `start` high for 18 consecutive cycles with data 0..17 → words 0..16 accepted. Word 17 is dropped with one `overflow` pulse. `full` = 1 and `fifo_count` = 16 after the 17th edge.
4. Write 0x00 then 0xFF on consecutive cycles → two 160-clock frames with no gap between them. `busy` stays continuously high.
5. Assert `rst` mid-DATA of a frame, with 3 words queued → `tx` = 1, `busy` = 0, `fifo_count` = 0 immediately. After release, nothing is transmitted until a new write.
6. Write on the exact edge the STOP terminal count pops the last queued word → the word is accepted and `fifo_count` = 1. The next frame follows back-to-back after the current one.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter fed by a write FIFO; tx falls one clock after a write to an idle block.
// Writes are refused while full (overflow pulses); queued frames leave back-to-back.
module uart_tx_frame #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int BAUD_TICK  = CLK_FREQ / BAUD_RATE,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          start,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx,
    output logic                          busy
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(BAUD_TICK);
    localparam int NW  = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_TICK - 1);
    localparam logic [NW-1:0]  DATA_LAST = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0]  STOP_LAST = NW'(STOP_BITS - 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);

    if (BAUD_TICK < 2) begin : g_bad_baud
        $error("uart_tx_frame: BAUD_TICK must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_full, r_overflow, r_tx, r_busy, r_par_bit;
    state_t               r_state;
    logic [BCW-1:0]       r_baud_cnt;
    logic [NW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    logic                 w_wr_en, w_pop, w_baud_tc, w_head_par, w_par_nxt, w_tx_nxt, w_busy_nxt;
    logic [DATA_BITS-1:0] w_head, w_shift_nxt;
    logic [CW-1:0]        w_count_nxt;
    state_t               w_state_nxt;
    logic [BCW-1:0]       w_baud_nxt;
    logic [NW-1:0]        w_bit_nxt;

    assign w_wr_en    = start & ~r_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_par = (PARITY == 1) ? ~(^w_head) : (^w_head);
    assign w_baud_tc  = (r_baud_cnt == BAUD_LAST);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_en, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par_bit;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        if (r_state != S_IDLE) begin
            w_baud_nxt = w_baud_tc ? '0 : r_baud_cnt + BCW'(1);
        end
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (r_count != '0) w_pop = 1'b1;
            end
            S_START: begin
                if (w_baud_tc) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_tc) begin
                    if (r_bit_cnt == DATA_LAST) begin
                        w_bit_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PARITY;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit_cnt + NW'(1);
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_tc) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_tc) begin
                    if (r_bit_cnt != STOP_LAST) begin
                        w_bit_nxt = r_bit_cnt + NW'(1);
                    end else if (r_count != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
        // A pop always starts a fresh frame, from IDLE or straight out of the last stop bit.
        if (w_pop) begin
            w_shift_nxt = w_head;
            w_par_nxt   = w_head_par;
            w_baud_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
        end
    end

    assign w_busy_nxt = (w_state_nxt != S_IDLE) || (w_count_nxt != '0);

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == DEPTH_C);
            r_overflow <= start & r_full;
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par_bit  <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign full       = r_full;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign tx         = r_tx;
    assign busy       = r_busy;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: 8N1 instance checked every cycle against a queue/frame-offset model,
// plus 7E2 and 7O2 instances checked against hand-written bit sequences.
module tb_uart_tx_frame;
    localparam int BT    = 16;
    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int FRAME = (1 + DB + 1) * BT;

    logic       clk;
    logic       rst   = 1'b1;
    logic [7:0] data  = '0;
    logic       start = 1'b0;
    logic       full, overflow, tx, busy;
    logic [4:0] fifo_count;

    logic [6:0] data7  = '0;
    logic       start7 = 1'b0;
    logic       full_e, ovf_e, tx_e, busy_e, full_o, ovf_o, tx_o, busy_o;
    logic [2:0] cnt_e, cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_frame #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .data(data), .start(start), .full(full),
        .fifo_count(fifo_count), .overflow(overflow), .tx(tx), .busy(busy));

    uart_tx_frame #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_even (
        .clk(clk), .rst(rst), .data(data7), .start(start7), .full(full_e),
        .fifo_count(cnt_e), .overflow(ovf_e), .tx(tx_e), .busy(busy_e));

    uart_tx_frame #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_odd (
        .clk(clk), .rst(rst), .data(data7), .start(start7), .full(full_o),
        .fifo_count(cnt_o), .overflow(ovf_o), .tx(tx_o), .busy(busy_o));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word queue plus the clock offset into the frame currently on the line.
    logic [7:0] mq[$];
    bit         m_fly = 1'b0;
    int         m_t   = 0;
    logic [7:0] m_cur = '0;
    bit         m_ovf = 1'b0;

    function automatic logic frame_bit(input logic [7:0] w, input int idx);
        logic [7:0] s;
        if (idx == 0) return 1'b0;
        if (idx > DB) return 1'b1;
        s = w >> (idx - 1);
        return s[0];
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_fly = 1'b0;
            m_t   = 0;
            m_ovf = 1'b0;
        end else begin
            bit was_full, nonempty;
            was_full = (mq.size() == DEPTH);
            nonempty = (mq.size() != 0);
            m_ovf    = start && was_full;
            if (m_fly) begin
                m_t++;
                if (m_t == FRAME) begin
                    if (nonempty) begin
                        m_cur = mq.pop_front();
                        m_t   = 0;
                    end else begin
                        m_fly = 1'b0;
                    end
                end
            end else if (nonempty) begin
                m_cur = mq.pop_front();
                m_t   = 0;
                m_fly = 1'b1;
            end
            if (start && !was_full) mq.push_back(data);
        end
    end

    bit cmp_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            logic [8:0] e;
            e = {(m_fly ? frame_bit(m_cur, m_t / BT) : 1'b1), (m_fly || mq.size() != 0),
                 (mq.size() == DEPTH), m_ovf, 5'(mq.size())};
            chk("cycle_tx_busy_full_ovf_cnt", 32'({tx, busy, full, overflow, fifo_count}), 32'(e));
        end
    end

    logic tx_s [0:400];
    logic bz_s [0:400];

    task automatic sample(input int n);
        tx_s[n] = tx;
        bz_s[n] = busy;
    endtask

    task automatic capture(input int a, input int b);
        for (int n = a; n <= b; n++) begin
            @(negedge clk);
            sample(n);
        end
    endtask

    function automatic int busy_run(input int lim);
        int r;
        r = 0;
        while (r <= lim && bz_s[r] === 1'b1) r++;
        return r;
    endfunction

    task automatic wait_idle(input string name, input int limit);
        int k;
        k = 0;
        while (busy === 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(busy), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, busy=%0b", busy);
        $fatal(1, "watchdog");
    end

    logic [9:0]  exp_a5 = 10'b1101001010;
    logic [10:0] exp_e [2] = '{11'b11010000010, 11'b11111111110};
    logic [10:0] exp_o [2] = '{11'b11110000010, 11'b11011111110};
    logic [6:0]  words7 [2] = '{7'h41, 7'h7F};

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_cnt", 32'(fifo_count), 0);
        chk("reset_ovf", 32'(overflow), 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1, single word 0xA5
        start = 1'b1; data = 8'hA5;
        @(negedge clk); start = 1'b0; sample(0);
        chk("t1_cnt_after_write", 32'(fifo_count), 1);
        capture(1, 170);
        chk("t1_tx_fall", 32'(tx_s[1]), 0);
        for (int k = 0; k < 10; k++) chk($sformatf("t1_bit%0d", k), 32'(tx_s[9 + 16 * k]), 32'(exp_a5[k]));
        chk("t1_busy_cycles", busy_run(170), 161);
        chk("t1_tx_idle_after", 32'(tx_s[161]), 1);
        repeat (5) @(negedge clk);

        // 7-bit, two stop bits, even and odd parity side by side
        for (int w = 0; w < 2; w++) begin
            int run_e, run_o;
            logic [10:0] got_e, got_o;
            start7 = 1'b1; data7 = words7[w];
            @(negedge clk); start7 = 1'b0;
            chk("t2_cnt_even", 32'(cnt_e), 1);
            chk("t2_cnt_odd", 32'(cnt_o), 1);
            chk("t2_full_ovf", 32'({full_e, ovf_e, full_o, ovf_o}), 0);
            run_e = (busy_e === 1'b1) ? 1 : 0;
            run_o = (busy_o === 1'b1) ? 1 : 0;
            got_e = '0; got_o = '0;
            for (int n = 1; n <= 190; n++) begin
                @(negedge clk);
                if (busy_e === 1'b1 && run_e == n) run_e++;
                if (busy_o === 1'b1 && run_o == n) run_o++;
                if (n >= 9 && (n - 9) % 16 == 0 && (n - 9) / 16 < 11) begin
                    got_e[(n - 9) / 16] = tx_e;
                    got_o[(n - 9) / 16] = tx_o;
                end
            end
            chk($sformatf("t2_even_bits_w%0d", w), 32'(got_e), 32'(exp_e[w]));
            chk($sformatf("t2_odd_bits_w%0d", w), 32'(got_o), 32'(exp_o[w]));
            chk("t2_busy_cycles_even", run_e, 177);
            chk("t2_busy_cycles_odd", run_o, 177);
            chk("t2_idle_line", 32'({tx_e, tx_o}), 3);
        end

        // 0x00 then 0xFF on consecutive edges
        start = 1'b1; data = 8'h00;
        @(negedge clk); data = 8'hFF; sample(0);
        @(negedge clk); start = 1'b0; sample(1);
        chk("t4_cnt", 32'(fifo_count), 1);
        capture(2, 330);
        chk("t4_f1_data", 32'(tx_s[25]), 0);
        chk("t4_f1_stop", 32'(tx_s[160]), 1);
        chk("t4_f2_start", 32'(tx_s[161]), 0);
        chk("t4_f2_data", 32'(tx_s[185]), 1);
        chk("t4_busy_cycles", busy_run(330), 321);
        repeat (5) @(negedge clk);

        // write landing on the stop-bit terminal edge that pops the last queued word
        start = 1'b1; data = 8'h3C;
        @(negedge clk); data = 8'hC3; sample(0);
        @(negedge clk); start = 1'b0; sample(1);
        capture(2, 160);
        start = 1'b1; data = 8'h5A;
        @(negedge clk); start = 1'b0; sample(161);
        chk("t6_cnt_at_pop", 32'(fifo_count), 1);
        chk("t6_tx_start", 32'(tx_s[161]), 0);
        capture(162, 330);
        chk("t6_third_start", 32'(tx_s[321]), 0);
        chk("t6_busy_cycles", busy_run(330), 331);
        wait_idle("t6_drain", 400);
        repeat (3) @(negedge clk);

        // 18 consecutive writes into a depth-16 FIFO
        start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            data = 8'(i);
            @(negedge clk);
            if (i == 16) begin
                chk("t3_full_17th", 32'(full), 1);
                chk("t3_cnt_17th", 32'(fifo_count), 16);
                chk("t3_no_ovf_17th", 32'(overflow), 0);
            end
        end
        chk("t3_ovf_pulse", 32'(overflow), 1);
        chk("t3_cnt_18th", 32'(fifo_count), 16);
        start = 1'b0;
        @(negedge clk);
        chk("t3_ovf_single", 32'(overflow), 0);
        wait_idle("t3_drain", 4000);
        repeat (3) @(negedge clk);

        // asynchronous reset mid-frame with three words queued
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk("t5_cnt_before", 32'(fifo_count), 3);
        repeat (47) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_tx", 32'(tx), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_cnt", 32'(fifo_count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("t5_quiet_after", 32'({tx, busy, fifo_count}), 32'h40);

        // random bursts
        for (int b = 0; b < 12; b++) begin
            int gap, len;
            gap = $urandom_range(0, 250);
            len = $urandom_range(1, 8);
            repeat (gap) @(negedge clk);
            for (int j = 0; j < len; j++) begin
                start = ($urandom_range(0, 3) != 0);
                data  = 8'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
        end
        wait_idle("rand_drain", 20000);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
